// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined chunked adder: stage-count arithmetic
// and the per-stage control record carried down the pipeline.
package pipe_add_pkg;

    // Integer ceiling division used to size the pipeline at elaboration time.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Number of carry stages needed to cover a WIDTH-bit operand in CHUNK slices.
    function automatic int stage_count(input int width, input int chunk);
        return ceil_div(width, chunk);
    endfunction

    // Width of the topmost slice; equals CHUNK when WIDTH divides evenly.
    function automatic int last_width(input int width, input int chunk);
        return width - (stage_count(width, chunk) - 1) * chunk;
    endfunction

    // Control part of a stage register. The data part of the record (resolved
    // partial sum, remaining A and B') has a width that shrinks or grows with
    // the stage index, so it is declared per stage inside the top level.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_add_stage.sv
// One registered chunk adder: W-bit sum with carry in, carry out and the
// signed-overflow flag (carry into the MSB XOR carry out of the MSB).
module pipe_add_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_r,
    output logic         cout_r,
    output logic         ovf_r
);

    logic [W:0] full_s;
    logic       cmsb_s;

    // Chunk addition with one extra bit to capture the carry out.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        // The MSB sum bit is a ^ b ^ carry-in, so the carry into it is recovered here.
        cmsb_s = a[W-1] ^ b[W-1] ^ full_s[W-1];
    end

    // Result registers; they hold whenever the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (en) begin
            sum_r  <= full_s[W-1:0];
            cout_r <= full_s[W];
            ovf_r  <= cmsb_s ^ full_s[W];
        end
    end

endmodule

// File: rtl/pipe_add.sv
// Pipelined two's-complement adder/subtractor. One CHUNK-bit slice of the
// carry chain is resolved per stage; the whole pipeline advances under a
// single global enable derived from the output handshake.
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int WIDTH = 288,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stage_count(WIDTH, CHUNK);
    localparam int LASTW  = last_width(WIDTH, CHUNK);

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    // Global enable: the pipeline moves unless a finished result is waiting.
    always_comb begin
        en_s     = !out_valid || out_ready;
        in_ready = en_s;
    end

    // Subtraction is A + ~B + ~cin, so borrow-in inverts into carry-in.
    always_comb begin
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = ~cin;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * CHUNK;
        localparam int CW   = (k == STAGES - 1) ? LASTW : CHUNK;
        localparam int HI   = LO + CW;
        localparam int REMW = WIDTH - HI;

        logic                valid_in_s;
        logic                carry_in_s;
        logic [WIDTH-LO-1:0] src_a_s;
        logic [WIDTH-LO-1:0] src_b_s;
        logic                valid_r;
        logic [CW-1:0]       chunk_sum_s;
        logic                carry_s;
        logic                ovf_s;
        logic [HI-1:0]       psum_s;
        stage_ctl_t          ctl_s;

        if (k == 0) begin : g_first
            assign valid_in_s = in_valid;
            assign carry_in_s = c0_s;
            assign src_a_s    = a;
            assign src_b_s    = b_eff_s;
            assign psum_s     = chunk_sum_s;
        end else begin : g_next
            logic [LO-1:0] lo_r;

            assign valid_in_s = g_stage[k-1].ctl_s.valid;
            assign carry_in_s = g_stage[k-1].ctl_s.carry;
            assign src_a_s    = g_stage[k-1].g_rem.rem_a_r;
            assign src_b_s    = g_stage[k-1].g_rem.rem_b_r;
            assign psum_s     = {chunk_sum_s, lo_r};

            // Carry the already-resolved low sum chunks alongside the beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_r <= '0;
                end else if (en_s) begin
                    lo_r <= g_stage[k-1].psum_s;
                end
            end
        end

        if (REMW > 0) begin : g_rem
            logic [REMW-1:0] rem_a_r;
            logic [REMW-1:0] rem_b_r;

            // Upper operand slices not yet consumed travel to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a_r <= '0;
                    rem_b_r <= '0;
                end else if (en_s) begin
                    rem_a_r <= src_a_s[WIDTH-LO-1:CW];
                    rem_b_r <= src_b_s[WIDTH-LO-1:CW];
                end
            end
        end

        // Per-stage valid bit; bubbles shift along with data when enabled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
            end else if (en_s) begin
                valid_r <= valid_in_s;
            end
        end

        pipe_add_stage #(
            .W (CW)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en_s),
            .a      (src_a_s[CW-1:0]),
            .b      (src_b_s[CW-1:0]),
            .cin    (carry_in_s),
            .sum_r  (chunk_sum_s),
            .cout_r (carry_s),
            .ovf_r  (ovf_s)
        );

        assign ctl_s = '{valid: valid_r, carry: carry_s};
    end

    assign out_valid = g_stage[STAGES-1].ctl_s.valid;
    assign sum       = g_stage[STAGES-1].psum_s;
    assign cout      = g_stage[STAGES-1].ctl_s.carry;
    assign ovf       = g_stage[STAGES-1].ovf_s;

endmodule

// File: tb/tb_pipe_add.sv
// Bench for pipe_add: three instances (8/4, 288/32, 37/8) driven by vector
// tables, hand sequences and a random stream checked through scoreboards.
module tb_pipe_add;

    typedef struct packed {
        logic [287:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit instance
    logic v8 = 1'b0, r8, ov8, or8 = 1'b1, c8 = 1'b0, s8 = 1'b0, co8, of8;
    logic [7:0] a8 = 8'h00, b8 = 8'h00, sum8;
    // 288-bit instance
    logic v2 = 1'b0, r2, ov2, or2 = 1'b1, c2 = 1'b0, s2 = 1'b0, co2, of2;
    logic [287:0] a2 = '0, b2 = '0, sum2;
    // 37-bit instance
    logic v3 = 1'b0, r3, ov3, or3 = 1'b1, c3 = 1'b0, s3 = 1'b0, co3, of3;
    logic [36:0] a3 = '0, b3 = '0, sum3;

    pipe_add #(.WIDTH(8), .CHUNK(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .cin(c8), .sub(s8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
        .cout(co8), .ovf(of8));

    pipe_add #(.WIDTH(288), .CHUNK(32)) u288 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .a(a2), .b(b2),
        .cin(c2), .sub(s2), .out_valid(ov2), .out_ready(or2), .sum(sum2),
        .cout(co2), .ovf(of2));

    pipe_add #(.WIDTH(37), .CHUNK(8)) u37 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .a(a3), .b(b3),
        .cin(c3), .sub(s3), .out_valid(ov3), .out_ready(or3), .sum(sum3),
        .cout(co3), .ovf(of3));

    task automatic chk(input string name, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Bit-serial ripple reference model, independent of chunking.
    function automatic res_t model(input int w, input logic [287:0] a, input logic [287:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        logic c, cprev, bb;
        r = '0;
        c = sub ? ~cin : cin;
        cprev = c;
        for (int i = 0; i < w; i++) begin
            bb = sub ? ~b[i] : b[i];
            r.sum[i] = a[i] ^ bb ^ c;
            cprev = c;
            c = (a[i] & bb) | (a[i] & c) | (bb & c);
        end
        r.cout = c;
        r.ovf = c ^ cprev;
        return r;
    endfunction

    res_t q8[$];
    res_t q3[$];
    res_t exp8 = '0;
    res_t e8, e3;
    int out3_cnt = 0;
    logic stall_prev = 1'b0;
    logic [38:0] held3 = '0;

    // Scoreboard for the 8-bit instance: compare at output, push at acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u8_unexpected got=%0h exp=none", sum8);
                end else begin
                    e8 = q8.pop_front();
                    chk("u8_sum", {280'b0, sum8}, e8.sum);
                    chk("u8_cout", {287'b0, co8}, {287'b0, e8.cout});
                    chk("u8_ovf", {287'b0, of8}, {287'b0, e8.ovf});
                end
            end
            if (v8 && r8) q8.push_back(exp8);
        end
    end

    // Scoreboard and stall-stability monitor for the 37-bit instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (ov3 && or3) begin
                out3_cnt++;
                if (q3.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u37_unexpected got=%0h exp=none", sum3);
                end else begin
                    e3 = q3.pop_front();
                    chk("u37_sum", {251'b0, sum3}, e3.sum);
                    chk("u37_cout", {287'b0, co3}, {287'b0, e3.cout});
                    chk("u37_ovf", {287'b0, of3}, {287'b0, e3.ovf});
                end
            end
            if (ov3 && !or3) begin
                if (stall_prev) chk("u37_stall_hold", {249'b0, co3, of3, sum3}, {249'b0, held3});
                held3 = {co3, of3, sum3};
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (v3 && r3) q3.push_back(model(37, {251'b0, a3}, {251'b0, b3}, c3, s3));
        end
    end

    task automatic run288(input string name, input logic [287:0] a, input logic [287:0] b,
                          input logic cin, input logic sub, input logic [287:0] es,
                          input logic eco, input logic eov);
        int n;
        @(posedge clk); #1;
        v2 = 1'b1; a2 = a; b2 = b; c2 = cin; s2 = sub;
        @(posedge clk); #1;
        v2 = 1'b0;
        n = 1;
        while (!ov2 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int({name, "_latency"}, n, 9);
        chk({name, "_sum"}, sum2, es);
        chk({name, "_cout"}, {287'b0, co2}, {287'b0, eco});
        chk({name, "_ovf"}, {287'b0, of2}, {287'b0, eov});
    endtask

    vec_t tbl[9];
    logic [287:0] ones288;
    int n, sent, base, cyc, acc;

    initial begin
        tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[3] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[5] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
        tbl[6] = '{8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[8] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
        ones288 = '1;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_u8_valid", {287'b0, ov8}, 288'd0);
        chk("rst_u8_sum", {280'b0, sum8}, 288'd0);
        chk("rst_u8_flags", {286'b0, co8, of8}, 288'd0);
        chk("rst_u8_ready", {287'b0, r8}, 288'd1);
        chk("rst_u288_sum", sum2, 288'd0);
        chk("rst_u37_valid", {287'b0, ov3}, 288'd0);

        // Latency of the 8-bit instance (two stages)
        @(posedge clk); #1;
        v8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; s8 = 1'b0;
        exp8 = '{288'h80, 1'b0, 1'b1};
        @(posedge clk); #1;
        v8 = 1'b0;
        n = 1;
        while (!ov8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("u8_latency", n, 2);

        // Vector table streamed back-to-back
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            v8 = 1'b1; a8 = tbl[i].a; b8 = tbl[i].b; c8 = tbl[i].cin; s8 = tbl[i].sub;
            exp8 = '{{280'b0, tbl[i].s}, tbl[i].co, tbl[i].ov};
        end
        @(posedge clk); #1;
        v8 = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("u8_drain", q8.size(), 0);

        // Full carry ripple across nine stages
        run288("u288_ripple", ones288, 288'd0, 1'b1, 1'b0, 288'd0, 1'b1, 1'b0);
        run288("u288_sub0", 288'd0, 288'd0, 1'b0, 1'b1, 288'd0, 1'b1, 1'b0);
        run288("u288_sub1", 288'd0, 288'd0, 1'b1, 1'b1, ones288, 1'b0, 1'b0);

        // Back-pressure: six beats, output stalled for three cycles mid-stream
        sent = 0;
        base = out3_cnt;
        cyc = 0;
        while ((sent < 6 || q3.size() != 0) && cyc < 60) begin
            @(posedge clk); #1;
            or3 = !(cyc >= 6 && cyc <= 8);
            v3 = (sent < 6);
            a3 = 37'({$urandom(), $urandom()});
            b3 = 37'({$urandom(), $urandom()});
            c3 = 1'($urandom_range(0, 1));
            s3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!or3 && ov3) chk("u37_inready_stall", {287'b0, r3}, 288'd0);
            if (v3 && r3) sent++;
            cyc++;
        end
        chk_int("u37_bp_sent", sent, 6);
        chk_int("u37_bp_outputs", out3_cnt - base, 6);

        // Asynchronous reset with beats in flight and one result stalled
        @(posedge clk); #1;
        v3 = 1'b0; or3 = 1'b0;
        v3 = 1'b1;
        n = 0;
        while (!ov3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("u37_pre_reset_valid", {287'b0, ov3}, 288'd1);
        #1;
        rst_n = 1'b0;
        v3 = 1'b0;
        #1;
        chk("u37_async_valid", {287'b0, ov3}, 288'd0);
        chk("u37_async_sum", {251'b0, sum3}, 288'd0);
        chk("u37_async_ready", {287'b0, r3}, 288'd1);
        q3.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        or3 = 1'b1;
        base = out3_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk_int("u37_no_stale", out3_cnt - base, 0);

        // Random stream with random back-pressure
        acc = 0;
        cyc = 0;
        base = out3_cnt;
        while (acc < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            v3 = ($urandom_range(0, 4) != 0);
            or3 = ($urandom_range(0, 3) != 0);
            a3 = 37'({$urandom(), $urandom()});
            b3 = 37'({$urandom(), $urandom()});
            c3 = 1'($urandom_range(0, 1));
            s3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (v3 && r3) acc++;
            cyc++;
        end
        @(posedge clk); #1;
        v3 = 1'b0; or3 = 1'b1;
        n = 0;
        while (q3.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk_int("u37_rand_accepted", acc, 10000);
        chk_int("u37_rand_drain", q3.size(), 0);
        chk_int("u37_rand_outputs", out3_cnt - base, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
